// File: rtl/gnrl_sync_fifo.sv
`default_nettype none
// ============================================================================
// gnrl_sync_fifo : synchronous valid/ready FIFO, output zero-masked when empty
// Revision: 1.0
// ============================================================================
module gnrl_sync_fifo #(
   parameter int DW = 32,
   parameter int DP = 4,
   localparam int AW = $clog2(DP)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_vld,
   output logic          i_rdy,
   input  logic [DW-1:0] i_dat,
   output logic          o_vld,
   input  logic          o_rdy,
   output logic [DW-1:0] o_dat,
   output logic [AW:0]   cnt,
   output logic          full,
   output logic          empty
);

   logic [DW-1:0] mem_q [DP];
   logic [AW:0]   wptr_q, wptr_d;
   logic [AW:0]   rptr_q, rptr_d;
   logic [AW:0]   cnt_q,  cnt_d;

   logic          w_push;
   logic          w_pop;
   logic [AW-1:0] w_wr_idx;
   logic [AW-1:0] w_rd_idx;

   assign w_wr_idx = wptr_q[AW-1:0];
   assign w_rd_idx = rptr_q[AW-1:0];

   // Full/empty come from registered pointers only, so i_rdy has no path from o_rdy.
   assign empty = (wptr_q == rptr_q);
   assign full  = (w_wr_idx == w_rd_idx) && (wptr_q[AW] != rptr_q[AW]);
   assign i_rdy = ~full;
   assign o_vld = ~empty;
   assign cnt   = cnt_q;

   assign w_push = i_vld & i_rdy;
   assign w_pop  = o_vld & o_rdy;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (w_push) wptr_d = wptr_q + 1'b1;
      if (w_pop)  rptr_d = rptr_q + 1'b1;
      case ({w_push, w_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Storage is intentionally not reset; the output mask hides stale contents.
   generate
      for (genvar gi = 0; gi < DP; gi++) begin : g_mem
         always_ff @(posedge clk) begin
            if (w_push && (w_wr_idx == AW'(gi))) begin
               mem_q[gi] <= i_dat;
            end
         end
      end
   endgenerate

   assign o_dat = o_vld ? mem_q[w_rd_idx] : {DW{1'b0}};

endmodule
`default_nettype wire
